// File: rtl/serial_word_adder.sv
// Word-serial adder: one N-bit fulladder slice reused across WORDS beats, LS word first,
// with the inter-word carry held in a register between beats.

module fulladder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] total;

  always_comb begin
    total = {1'b0, in1} + {1'b0, in2} + {{N{1'b0}}, cin};
    sum   = total[N-1:0];
    cout  = total[N];
  end

endmodule

module serial_word_adder #(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cin,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_word,
  input  logic [N-1:0] b_word,
  output logic [N-1:0] sum_word,
  output logic         sum_valid,
  output logic         carry_out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    fa_sum;
  logic            fa_cout;
  logic            accept;

  fulladder #(.N(N)) u_fulladder (
    .in1  (a_word),
    .in2  (b_word),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept = (state_q == StRun) && in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_word  <= '0;
      sum_valid <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sum_valid <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            carry_q   <= cin;
            cnt_q     <= '0;
            carry_out <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          // Stalls leave carry_q and cnt_q untouched so no beat is lost.
          sum_valid <= accept;
          if (accept) begin
            sum_word <= fa_sum;
            carry_q  <= fa_cout;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              carry_out <= fa_cout;
              done      <= 1'b1;
              in_ready  <= 1'b0;
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          done      <= 1'b0;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: directed and random additions checked against whole-operand
// arithmetic on WORDS*N-bit values.

module tb_serial_word_adder;

  localparam int unsigned N     = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_word;
  logic [N-1:0] b_word;
  logic [N-1:0] sum_word;
  logic         sum_valid;
  logic         carry_out;
  logic         done;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;

  serial_word_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .sum_word  (sum_word),
    .sum_valid (sum_valid),
    .carry_out (carry_out),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sum_word"}, 32'(sum_word), 32'd0);
    chk({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
    chk({tag, "_carry_out"}, 32'(carry_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One full addition; gap idle cycles follow every beat, poke re-pulses start mid-run.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int gap, input bit poke);
    logic [W:0] full;
    int         sent;
    int         idle;
    int         cyc;
    bit         acc;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    start = 1'b1;
    cin = c;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
    idle = 0;
    cyc = 0;
    while (sent < WORDS && cyc < 200) begin
      chk("run_in_ready", 32'(in_ready), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      acc = (idle == 0);
      in_valid = acc;
      a_word = acc ? a[sent*N +: N] : N'($urandom);
      b_word = acc ? b[sent*N +: N] : N'($urandom);
      start = poke && (cyc == 1);
      cin = ~c;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      cyc++;
      if (acc) begin
        chk("beat_sum_valid", 32'(sum_valid), 32'd1);
        chk("beat_sum_word", 32'(sum_word), 32'(full[sent*N +: N]));
        chk("beat_done", 32'(done), (sent == WORDS - 1) ? 32'd1 : 32'd0);
        if (sent == WORDS - 1) chk("final_carry", 32'(carry_out), 32'(full[W]));
        sent++;
        idle = gap;
      end else begin
        chk("gap_sum_valid", 32'(sum_valid), 32'd0);
        chk("gap_done", 32'(done), 32'd0);
        idle--;
      end
    end
    if (sent < WORDS) chk("beat_timeout", 32'(sent), 32'(WORDS));
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_sum_valid", 32'(sum_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd0);
    chk("post_carry_hold", 32'(carry_out), 32'(full[W]));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cin = 1'b0;
    in_valid = 1'b0;
    a_word = '0;
    b_word = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Beats offered in IDLE must be ignored.
    in_valid = 1'b1;
    a_word = 8'hAA;
    b_word = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_sum_valid", 32'(sum_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    run_add(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0);
    run_add(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
    run_add(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0);
    run_add(32'hFFFFFFFF, 32'h00000001, 1'b0, 3, 1'b0);

    // Reset after two beats of an all-carry addition, then a clean run.
    start = 1'b1;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_word = 8'hFF;
      b_word = (i == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_reset_done", 32'(done), 32'd0);
    run_add(32'h00000000, 32'h00000000, 1'b1, 0, 1'b0);

    run_add(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      run_add($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
